// File: rtl/dual_tone_stimulus_gen_if.sv
// Signal bundle between the dual-tone source, its two CORDIC sine engines and the downstream FIR.
// The master modport is the generator's view; the slave modport is the surrounding environment's view.
interface dual_tone_stimulus_gen_if #(
    parameter int PHASE_W = 16,
    parameter int DATA_W  = 16
);
    logic                      EN;
    logic        [PHASE_W-1:0] PHASE_INC_A;
    logic        [PHASE_W-1:0] PHASE_INC_B;
    logic signed [PHASE_W-1:0] Phase_A;
    logic signed [PHASE_W-1:0] Phase_B;
    logic                      Phase_Valid;
    logic signed [DATA_W-1:0]  Sin_A;
    logic                      Sin_A_Valid;
    logic signed [DATA_W-1:0]  Sin_B;
    logic                      Sin_B_Valid;
    logic signed [DATA_W-1:0]  Signal_Noise;
    logic                      Signal_Valid;

    modport master (
        input  EN, PHASE_INC_A, PHASE_INC_B,
        input  Sin_A, Sin_A_Valid, Sin_B, Sin_B_Valid,
        output Phase_A, Phase_B, Phase_Valid,
        output Signal_Noise, Signal_Valid
    );

    modport slave (
        output EN, PHASE_INC_A, PHASE_INC_B,
        output Sin_A, Sin_A_Valid, Sin_B, Sin_B_Valid,
        input  Phase_A, Phase_B, Phase_Valid,
        input  Signal_Noise, Signal_Valid
    );
endinterface

// File: rtl/dual_tone_stimulus_gen.sv
// Two +/-pi wrapping phase accumulators feeding CORDIC sine engines, with the returned sines
// averaged into one composite sample and decimated down to the FIR sample rate.
module dual_tone_stimulus_gen #(
    parameter int DECIM   = 5,
    parameter int PHASE_W = 16,
    parameter int DATA_W  = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    dual_tone_stimulus_gen_if.master bus
);
    localparam logic        [PHASE_W-1:0] PI_POS_U = PHASE_W'(25736);
    localparam logic signed [PHASE_W:0]   PI_POS   = (PHASE_W+1)'(25736);
    localparam logic signed [PHASE_W:0]   TWO_PI   = (PHASE_W+1)'(51472);
    localparam logic        [7:0]         LAST     = 8'(DECIM - 1);

    logic signed [PHASE_W-1:0] phase_a_q, phase_a_d;
    logic signed [PHASE_W-1:0] phase_b_q, phase_b_d;
    logic                      phase_vld_q;
    logic signed [DATA_W-1:0]  held_a_q, held_b_q;
    logic signed [DATA_W-1:0]  mix_q, mix_d;
    logic        [7:0]         cnt_q;
    logic signed [DATA_W-1:0]  sig_q;
    logic                      sig_vld_q;

    // Step is clamped to pi so a single wrap by 2*pi always lands back inside [-pi, pi].
    function automatic logic signed [PHASE_W-1:0] phase_next(
        input logic signed [PHASE_W-1:0] ph,
        input logic        [PHASE_W-1:0] inc
    );
        logic        [PHASE_W-1:0] inc_eff;
        logic signed [PHASE_W:0]   s;
        inc_eff = (inc > PI_POS_U) ? PI_POS_U : inc;
        s = $signed({ph[PHASE_W-1], ph}) + $signed({1'b0, inc_eff});
        if (s > PI_POS) begin
            s = s - TWO_PI;
        end
        return s[PHASE_W-1:0];
    endfunction

    // Halving with truncation toward zero: bias negative sums by one before the arithmetic shift.
    function automatic logic signed [DATA_W-1:0] mix_avg(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [DATA_W:0] s;
        s = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
        if (s[DATA_W]) begin
            s = s + (DATA_W+1)'(1);
        end
        s = s >>> 1;
        return s[DATA_W-1:0];
    endfunction

    assign phase_a_d = phase_next(phase_a_q, bus.PHASE_INC_A);
    assign phase_b_d = phase_next(phase_b_q, bus.PHASE_INC_B);
    assign mix_d     = mix_avg(held_a_q, held_b_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            phase_a_q   <= '0;
            phase_b_q   <= '0;
            phase_vld_q <= 1'b0;
            held_a_q    <= '0;
            held_b_q    <= '0;
            mix_q       <= '0;
            cnt_q       <= '0;
            sig_q       <= '0;
            sig_vld_q   <= 1'b0;
        end else begin
            phase_vld_q <= bus.EN;
            mix_q       <= mix_d;
            if (bus.Sin_A_Valid) held_a_q <= bus.Sin_A;
            if (bus.Sin_B_Valid) held_b_q <= bus.Sin_B;
            sig_vld_q   <= 1'b0;
            if (bus.EN) begin
                phase_a_q <= phase_a_d;
                phase_b_q <= phase_b_d;
                if (cnt_q == LAST) begin
                    cnt_q     <= '0;
                    sig_q     <= mix_q;
                    sig_vld_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    assign bus.Phase_A      = phase_a_q;
    assign bus.Phase_B      = phase_b_q;
    assign bus.Phase_Valid  = phase_vld_q;
    assign bus.Signal_Noise = sig_q;
    assign bus.Signal_Valid = sig_vld_q;
endmodule

// File: tb/tb_dual_tone_stimulus_gen.sv
// Bench for dual_tone_stimulus_gen: integer reference model, per-cycle compare, directed literal cases
// and a randomized run.
module tb_dual_tone_stimulus_gen;
    localparam int DECIM = 5;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    dual_tone_stimulus_gen_if #(.PHASE_W(16), .DATA_W(16)) bus ();

    dual_tone_stimulus_gen #(.DECIM(DECIM), .PHASE_W(16), .DATA_W(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // Reference state as plain integers.
    int m_pa, m_pb, m_pv, m_ha, m_hb, m_mix, m_cnt, m_sn, m_sv;

    function automatic int wrap_add(int p, int inc);
        int e;
        int s;
        e = (inc > 25736) ? 25736 : inc;
        s = p + e;
        if (s > 25736) s = s - 51472;
        return s;
    endfunction

    function automatic void check(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endfunction

    always @(posedge CLK) begin
        int nmix;
        if (RST) begin
            m_pa = 0; m_pb = 0; m_pv = 0; m_ha = 0; m_hb = 0;
            m_mix = 0; m_cnt = 0; m_sn = 0; m_sv = 0;
        end else begin
            nmix = (m_ha + m_hb) / 2;
            m_sv = 0;
            if (bus.EN) begin
                m_pa = wrap_add(m_pa, int'(bus.PHASE_INC_A));
                m_pb = wrap_add(m_pb, int'(bus.PHASE_INC_B));
                if (m_cnt == DECIM - 1) begin
                    m_sn = m_mix;
                    m_sv = 1;
                end
                m_cnt = (m_cnt + 1) % DECIM;
            end
            m_pv = bus.EN ? 1 : 0;
            if (bus.Sin_A_Valid) m_ha = int'(bus.Sin_A);
            if (bus.Sin_B_Valid) m_hb = int'(bus.Sin_B);
            m_mix = nmix;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("Phase_A",      int'(bus.Phase_A),      m_pa);
            check("Phase_B",      int'(bus.Phase_B),      m_pb);
            check("Phase_Valid",  int'(bus.Phase_Valid),  m_pv);
            check("Signal_Valid", int'(bus.Signal_Valid), m_sv);
            check("Signal_Noise", int'(bus.Signal_Noise), m_sn);
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.EN = 1'b1;
        bus.Sin_A_Valid = 1'b1;
        bus.Sin_B_Valid = 1'b1;
        bus.Sin_A = 16'sd1234;
        bus.Sin_B = -16'sd777;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            chk_en = 1;
            check("rst_phase_a", int'(bus.Phase_A), 0);
            check("rst_sig_vld", int'(bus.Signal_Valid), 0);
            check("rst_sig",     int'(bus.Signal_Noise), 0);
        end
        RST = 1'b0;
        bus.Sin_A_Valid = 1'b0;
        bus.Sin_B_Valid = 1'b0;
        bus.PHASE_INC_A = '0;
        bus.PHASE_INC_B = '0;
    endtask

    // Load sines, let them settle past the pipeline, then read the next decimated sample.
    task automatic mix_case(string nm, bit va, int a, bit vb, int b, int exp);
        bit seen;
        bus.Sin_A_Valid = va;
        bus.Sin_B_Valid = vb;
        bus.Sin_A = 16'(a);
        bus.Sin_B = 16'(b);
        tick(1);
        bus.Sin_A_Valid = 1'b0;
        bus.Sin_B_Valid = 1'b0;
        tick(8);
        seen = 0;
        for (int i = 0; i < 2 * DECIM && !seen; i++) begin
            tick(1);
            if (bus.Signal_Valid) seen = 1;
        end
        if (!seen) check({nm, "_timeout"}, 0, 1);
        else check(nm, int'(bus.Signal_Noise), exp);
    endtask

    initial begin
        RST = 1'b1;
        bus.EN = 1'b0;
        bus.PHASE_INC_A = '0;
        bus.PHASE_INC_B = '0;
        bus.Sin_A = '0;
        bus.Sin_B = '0;
        bus.Sin_A_Valid = 1'b0;
        bus.Sin_B_Valid = 1'b0;

        // T1 / T2: wrap of tone A
        do_reset();
        bus.PHASE_INC_A = 16'd200;
        tick(128);
        check("T2_pa_25600", int'(bus.Phase_A), 25600);
        tick(1);
        check("T2_pa_wrap", int'(bus.Phase_A), -25672);

        // T3: wrap of tone B and exact-pi edge
        do_reset();
        bus.PHASE_INC_B = 16'd24000;
        tick(1);
        bus.PHASE_INC_B = 16'd3000;
        tick(1);
        check("T3_pb_wrap", int'(bus.Phase_B), -24472);
        do_reset();
        bus.PHASE_INC_B = 16'd22736;
        tick(1);
        bus.PHASE_INC_B = 16'd3000;
        tick(1);
        check("T3_pb_edge", int'(bus.Phase_B), 25736);

        // T4: increment clamp
        do_reset();
        bus.PHASE_INC_A = 16'hFFFF;
        check("T4_pa0", int'(bus.Phase_A), 0);
        tick(1);
        check("T4_pa1", int'(bus.Phase_A), 25736);
        tick(1);
        check("T4_pa2", int'(bus.Phase_A), 0);
        tick(1);
        check("T4_pa3", int'(bus.Phase_A), 25736);

        // T5: mix truncation toward zero
        do_reset();
        mix_case("T5_mix_a", 1, 16384, 1, -1, 8191);
        mix_case("T5_mix_b", 1, -3, 1, 0, -1);
        mix_case("T5_mix_c", 1, 32767, 1, 32767, 32767);
        mix_case("T5_mix_d", 1, -32768, 1, -32768, -32768);
        mix_case("T5_mix_e", 1, 0, 1, 100, 50);
        mix_case("T5_mix_f", 1, 300, 0, 5555, 200);

        // T6: decimation, enable freeze, mid-run reset
        do_reset();
        bus.PHASE_INC_A = 16'd200;
        tick(4);
        check("T6_no_pulse4", int'(bus.Signal_Valid), 0);
        tick(1);
        check("T6_pulse5", int'(bus.Signal_Valid), 1);
        check("T6_pa5", int'(bus.Phase_A), 1000);
        tick(2);
        check("T6_pa7", int'(bus.Phase_A), 1400);
        bus.EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("T6_frz_vld", int'(bus.Signal_Valid), 0);
            check("T6_frz_pa", int'(bus.Phase_A), 1400);
            check("T6_frz_pv", int'(bus.Phase_Valid), 0);
        end
        bus.EN = 1'b1;
        tick(2);
        check("T6_resume_nopulse", int'(bus.Signal_Valid), 0);
        tick(1);
        check("T6_resume_pulse", int'(bus.Signal_Valid), 1);
        check("T6_resume_pa", int'(bus.Phase_A), 2000);
        do_reset();
        bus.PHASE_INC_A = 16'd200;
        tick(4);
        check("T6_rst_nopulse", int'(bus.Signal_Valid), 0);
        tick(1);
        check("T6_rst_pulse", int'(bus.Signal_Valid), 1);
        check("T6_rst_pa", int'(bus.Phase_A), 1000);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            RST = ($urandom_range(0, 199) == 0);
            bus.EN = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) begin
                bus.PHASE_INC_A = 16'($urandom);
                bus.PHASE_INC_B = 16'($urandom);
            end else if ($urandom_range(0, 31) == 0) begin
                bus.PHASE_INC_A = 16'($urandom_range(0, 4000));
                bus.PHASE_INC_B = 16'($urandom_range(20000, 26000));
            end
            bus.Sin_A = 16'($urandom);
            bus.Sin_B = 16'($urandom);
            bus.Sin_A_Valid = $urandom_range(0, 1) == 1;
            bus.Sin_B_Valid = $urandom_range(0, 2) == 0;
            tick(1);
        end
        RST = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
